// File: rtl/sobel_pkg.sv
// Shared widths and helpers for the 3x3 sliding-window block.
package sobel_pkg;

  localparam int PIX_W = 16;
  localparam int WIN_N = 9;
  localparam int WIN_W = PIX_W * WIN_N;

  typedef logic [PIX_W-1:0] pix_t;

  // LSB position of window element (r,c) inside the packed window bus.
  function automatic int win_lsb(input int r, input int c);
    return PIX_W * (3 * r + c);
  endfunction

endpackage

// File: rtl/sobel_window_line_delay.sv
// Fixed-depth pixel delay line: dout_o is the pixel written DEPTH enables ago.
module line_delay #(
  parameter int DEPTH = 5,
  parameter int PIX_W = sobel_pkg::PIX_W
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [PIX_W-1:0] din_i,
  output logic [PIX_W-1:0] dout_o
);

  // Contents are don't-care after reset; the window valid logic masks them.
  logic [PIX_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign dout_o = mem_q[DEPTH-1];

endmodule

// File: rtl/sobel_window.sv
// 3x3 raster window generator: two line delays feed a 3x3 register; flags
// windows that lie fully inside the frame and pulses at the last pixel.
module sobel_window
  import sobel_pkg::*;
#(
  parameter int W = 5,
  parameter int H = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_data,
  output logic             win_valid,
  output logic [WIN_W-1:0] win_data,
  output logic             frame_done
);

  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          win_valid_q, win_valid_d;
  logic          frame_done_q, frame_done_d;
  pix_t          win_q [3][3];
  pix_t          win_d [3][3];
  pix_t          d0_out, d1_out;
  logic          accept;

  // Pixels presented while in reset must not disturb the line delays.
  assign accept = in_valid & ~rst;

  line_delay #(.DEPTH(W), .PIX_W(PIX_W)) u_delay0 (
    .clk    (clk),
    .en_i   (accept),
    .din_i  (in_data),
    .dout_o (d0_out)
  );

  line_delay #(.DEPTH(W), .PIX_W(PIX_W)) u_delay1 (
    .clk    (clk),
    .en_i   (accept),
    .din_i  (d0_out),
    .dout_o (d1_out)
  );

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (in_valid) begin
      win_valid_d  = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
      frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[2][2] = in_data;
      win_d[1][2] = d0_out;
      win_d[0][2] = d1_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  always_comb begin
    win_data = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_data[win_lsb(r, c) +: PIX_W] = win_q[r][c];
      end
    end
  end

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule
